// File: rtl/udp_tx_buffer.sv
// ============================================================================
// Module      : udp_tx_buffer
// Description : Store-and-forward buffer behind the UDP encoder. Captures the
//               32-bit word stream, patches the late checksum into the UDP
//               header, and replays the datagram over a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module udp_tx_buffer #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_wr_en,
    input  logic        in_fin,
    input  logic [15:0] in_checksum,
    input  logic [15:0] in_len,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [3:0]  out_be,
    output logic        busy,
    output logic        err,
    output logic [1:0]  err_code
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        CHECK = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [AW:0]   C_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   C_CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

    localparam logic [1:0] C_ERR_LEN  = 2'd1;
    localparam logic [1:0] C_ERR_OVF  = 2'd2;
    localparam logic [1:0] C_ERR_BUSY = 2'd3;

    // Packet storage; contents are don't-care after reset.
    logic [31:0] mem [DEPTH];

    state_t      state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic        ovf_q, ovf_d;
    logic [15:0] cks_q, cks_d;
    logic [15:0] len_q, len_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic [3:0]  out_be_q, out_be_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [16:0]   words_exp;

    // Next word to present: index 0 when leaving CHECK, rd_ptr+1 while draining.
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_word;
    logic          rd_is_last;
    logic [3:0]    rd_be;
    logic [3:0]    last_be;

    // Byte enables of the final word follow the residue of the byte length.
    always_comb begin
        case (len_q[1:0])
            2'd0:    last_be = 4'b1111;
            2'd1:    last_be = 4'b1000;
            2'd2:    last_be = 4'b1100;
            default: last_be = 4'b1110;
        endcase
    end

    // Fetch the upcoming output word and splice the checksum into header word 1.
    always_comb begin
        rd_addr = (state_q == DRAIN) ? (rd_ptr_q + C_PTR_ONE) : '0;
        rd_word = mem[rd_addr];
        if (rd_addr == C_PTR_ONE) begin
            rd_word[15:0] = cks_q;
        end
        rd_is_last = ({1'b0, rd_addr} == (count_q - C_CNT_ONE));
        rd_be      = rd_is_last ? last_be : 4'b1111;
    end

    // Control FSM next-state and datapath next-values.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        cks_d       = cks_q;
        len_d       = len_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_be_d    = out_be_q;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        mem_we      = 1'b0;
        mem_waddr   = wr_ptr_q;
        // 17-bit sum so a length near 16'hffff cannot wrap.
        words_exp   = ({1'b0, len_q} + 17'd3) >> 2;

        case (state_q)
            IDLE: begin
                if (in_wr_en) begin
                    mem_we    = 1'b1;
                    mem_waddr = '0;
                    wr_ptr_d  = C_PTR_ONE;
                    count_d   = C_CNT_ONE;
                    ovf_d     = 1'b0;
                    if (in_fin) begin
                        cks_d   = in_checksum;
                        len_d   = in_len;
                        state_d = CHECK;
                    end else begin
                        state_d = FILL;
                    end
                end else if (in_fin) begin
                    err_d      = 1'b1;
                    err_code_d = C_ERR_LEN;
                end
            end

            FILL: begin
                if (in_wr_en) begin
                    if (count_q == C_DEPTH) begin
                        ovf_d = 1'b1;
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + C_PTR_ONE;
                        count_d  = count_q + C_CNT_ONE;
                    end
                end
                if (in_fin) begin
                    if (ovf_d) begin
                        err_d      = 1'b1;
                        err_code_d = C_ERR_OVF;
                        state_d    = IDLE;
                    end else begin
                        cks_d   = in_checksum;
                        len_d   = in_len;
                        state_d = CHECK;
                    end
                end
            end

            CHECK: begin
                if (in_wr_en || in_fin) begin
                    err_d      = 1'b1;
                    err_code_d = C_ERR_BUSY;
                end
                if ((len_q < 16'd8) ||
                    (words_exp != {{(16-AW){1'b0}}, count_q})) begin
                    err_d      = 1'b1;
                    err_code_d = C_ERR_LEN;
                    state_d    = IDLE;
                end else begin
                    rd_ptr_d    = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = rd_word;
                    out_last_d  = rd_is_last;
                    out_be_d    = rd_be;
                    state_d     = DRAIN;
                end
            end

            default: begin // DRAIN
                if (in_wr_en || in_fin) begin
                    err_d      = 1'b1;
                    err_code_d = C_ERR_BUSY;
                end
                if (out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_be_d    = 4'b0000;
                        out_data_d  = '0;
                        state_d     = IDLE;
                    end else begin
                        rd_ptr_d   = rd_addr;
                        out_data_d = rd_word;
                        out_last_d = rd_is_last;
                        out_be_d   = rd_be;
                    end
                end
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any packet in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            cks_q       <= '0;
            len_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_be_q    <= 4'b0000;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            cks_q       <= cks_d;
            len_q       <= len_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_be_q    <= out_be_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    // Buffer write port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= in_data;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_be    = out_be_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

`default_nettype wire
